// File: rtl/mux_rr_n_1.sv
// -----------------------------------------------------------------------------
// mux_rr_n_1 -- N-to-1 channel multiplexer with a single-entry output register
//
// Picks one of N valid/ready input channels per cycle and loads its data into
// a registered output slot. The slot drains through out_valid/out_ready.
// Channel choice is either direct (sel) or round-robin starting at ptr.
//
// Configuration macro: MUX_RR_N_1_RR_EN
//   defined   : round-robin arbiter and its pointer are built; mode selects
//               direct (0) or round-robin (1).
//   undefined : direct selection only; mode is ignored and no pointer exists.
//
// Ports
//   clk        in   1        sole clock, rising edge
//   reset      in   1        synchronous, active-high reset
//   in         in   N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   in   N        per-channel data valid
//   in_ready   out  N        per-channel accept strobe (combinational, one-hot or zero)
//   sel        in   SW       channel index for direct mode
//   mode       in   1        0 = direct, 1 = round-robin
//   out        out  WIDTH    registered data of the held beat
//   out_valid  out  1        out holds an unconsumed beat
//   out_ready  in   1        downstream takes out this cycle
//   out_ch     out  SW       channel that produced out
// -----------------------------------------------------------------------------
module mux_rr_n_1 #(
   parameter int WIDTH = 8,
   parameter int N     = 8,
   parameter int SW    = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N*WIDTH-1:0]   in,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic [SW-1:0]        sel,
   input  logic                 mode,
   output logic [WIDTH-1:0]     out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SW-1:0]        out_ch
);

   // Output slot
   logic [WIDTH-1:0] out_q, out_d;
   logic [SW-1:0]    out_ch_q, out_ch_d;
   logic             out_valid_q, out_valid_d;

   // The slot can take a new beat when it is empty or being drained now.
   logic load_en;
   assign load_en = !out_valid_q || out_ready;

   // Direct selection: comparing against every legal index means an
   // out-of-range sel (>= N) simply never hits.
   logic dir_hit;
   always_comb begin
      dir_hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sel == SW'(i) && in_valid[i]) begin
            dir_hit = 1'b1;
         end
      end
   end

   logic          grant_ok;
   logic [SW-1:0] grant;

`ifdef MUX_RR_N_1_RR_EN
   // Round-robin pointer, always kept in 0..N-1.
   logic [SW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  hi_mask;
   logic [N-1:0]  req_hi;
   logic          rr_hit;
   logic [SW-1:0] rr_idx;

   // Channels at or above ptr are searched first; if none is valid the search
   // wraps to the lowest valid channel. Only indices < N exist, so the wrap is
   // modulo N regardless of whether N is a power of two.
   for (genvar gi = 0; gi < N; gi++) begin : g_hi_mask
      assign hi_mask[gi] = (SW'(gi) >= ptr_q);
   end
   assign req_hi = in_valid & hi_mask;

   always_comb begin
      rr_hit = |in_valid;
      rr_idx = '0;
      // Descending scan so the lowest set index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            rr_idx = SW'(i);
         end
      end
      if (|req_hi) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (req_hi[i]) begin
               rr_idx = SW'(i);
            end
         end
      end
   end

   assign grant_ok = mode ? rr_hit : dir_hit;
   assign grant    = mode ? rr_idx : sel;

   always_comb begin
      ptr_d = ptr_q;
      if (mode && load_en && grant_ok) begin
         ptr_d = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Direct-only build: mode has no effect.
   logic unused_mode;
   assign unused_mode = mode;

   assign grant_ok = dir_hit;
   assign grant    = sel;
`endif

   // Accept strobe for the granted channel only; forced low during reset so a
   // beat offered in a reset cycle is never considered taken.
   for (genvar gi = 0; gi < N; gi++) begin : g_in_ready
      assign in_ready[gi] = !reset && load_en && grant_ok && (grant == SW'(gi));
   end

   // Data of the granted channel.
   logic [WIDTH-1:0] grant_data;
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant == SW'(i)) begin
            grant_data = in[i*WIDTH +: WIDTH];
         end
      end
   end

   // Slot next state: load on grant, empty when a load opportunity finds
   // nothing, otherwise hold. out/out_ch keep their last value when emptied.
   always_comb begin
      out_d       = out_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      if (load_en) begin
         if (grant_ok) begin
            out_d       = grant_data;
            out_ch_d    = grant;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q       <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_n_1.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_n_1 -- self-checking bench for mux_rr_n_1 (N=8, WIDTH=8)
//
// A behavioural model (slot contents plus round-robin pointer) predicts
// in_ready and the registered outputs every cycle. Directed scenarios are
// followed by randomized traffic. Round-robin expectations follow
// MUX_RR_N_1_RR_EN exactly as the design under test is built.
// -----------------------------------------------------------------------------
module tb_mux_rr_n_1;
   localparam int N     = 8;
   localparam int WIDTH = 8;
   localparam int SW    = 3;

   logic                clk = 1'b0;
   logic                reset;
   logic [N*WIDTH-1:0]  in;
   logic [N-1:0]        in_valid;
   logic [N-1:0]        in_ready;
   logic [SW-1:0]       sel;
   logic                mode;
   logic [WIDTH-1:0]    out;
   logic                out_valid;
   logic                out_ready;
   logic [SW-1:0]       out_ch;

   mux_rr_n_1 #(.WIDTH(WIDTH), .N(N), .SW(SW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .mode      (mode),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch)
   );

   always #5 clk = ~clk;

   int err_count = 0;
   int chk_count = 0;

   // Model state
   logic       m_known = 1'b0;
   logic       m_valid;
   int         m_data;
   int         m_ch;
   int         m_ptr;
   logic [N-1:0] last_rdy;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      chk_count++;
      if (obs !== exp_v) begin
         err_count++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // One clock cycle: apply inputs, check predictions, advance the model.
   task automatic step(input logic r, input logic m, input logic [SW-1:0] s,
                       input logic [N-1:0] v, input logic [N*WIDTH-1:0] d,
                       input logic ordy);
      logic rr;
      logic can_load;
      int   g;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      reset = r; mode = m; sel = s; in_valid = v; in = d; out_ready = ordy;
      #1;
`ifdef MUX_RR_N_1_RR_EN
      rr = m;
`else
      rr = 1'b0;
`endif
      can_load = m_known && (!m_valid || ordy);
      g = -1;
      if (rr) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (g < 0 && v[c]) g = c;
         end
      end else if (int'(s) < N && v[s]) begin
         g = int'(s);
      end
      exp_rdy = (!r && can_load && g >= 0) ? (N'(1) << g) : '0;
      last_rdy = in_ready;
      check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (m_known) begin
         check_eq("out_valid", 64'(out_valid), 64'(m_valid));
         check_eq("out", 64'(out), 64'(m_data));
         check_eq("out_ch", 64'(out_ch), 64'(m_ch));
      end
      @(posedge clk);
      if (r) begin
         m_known = 1'b1; m_valid = 1'b0; m_data = 0; m_ch = 0; m_ptr = 0;
      end else if (can_load) begin
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = int'(d[g*WIDTH +: WIDTH]);
            m_ch    = g;
            if (rr) m_ptr = (g + 1) % N;
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
      $display("cyc rst=%0b mode=%0b sel=%0d valid=%02h ordy=%0b -> in_ready=%02h out_valid=%0b out=%02h out_ch=%0d",
               r, m, s, v, ordy, last_rdy, out_valid, out, out_ch);
   endtask

   function automatic logic [N*WIDTH-1:0] rnd_data();
      return {$urandom, $urandom};
   endfunction

   initial begin
      logic [N*WIDTH-1:0] d;
      logic [WIDTH-1:0]   held;
      int exp_seq [6] = '{0, 2, 7, 0, 2, 7};
      reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in = '0; out_ready = 1'b0;

      // Reset state
      step(1, 0, 0, 8'hFF, rnd_data(), 1);
      step(1, 0, 0, 8'hFF, rnd_data(), 1);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);

      // Direct mode, channel 3
      d = rnd_data(); d[3*WIDTH +: WIDTH] = 8'hA5;
      step(0, 0, 3, 8'hFF, d, 1);
      check_eq("direct_rdy", 64'(last_rdy), 64'h08);
      check_eq("direct_out", 64'(out), 64'hA5);
      check_eq("direct_ch", 64'(out_ch), 64'd3);

      // Backpressure: hold for 3 cycles with changing inputs
      held = out;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, SW'(i + 1), 8'hFF, rnd_data(), 0);
         check_eq("bp_rdy", 64'(last_rdy), 64'd0);
         check_eq("bp_hold", 64'(out), 64'(held));
      end
      d = rnd_data(); d[6*WIDTH +: WIDTH] = 8'h3C;
      step(0, 0, 6, 8'hFF, d, 1);
      check_eq("bp_nobubble_v", 64'(out_valid), 64'd1);
      check_eq("bp_nobubble_d", 64'(out), 64'h3C);

      // Round-robin from reset
      step(1, 1, 0, 8'h00, rnd_data(), 1);
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 0, 8'b1000_0101, rnd_data(), 1);
`ifdef MUX_RR_N_1_RR_EN
         check_eq("rr_seq", 64'(out_ch), 64'(exp_seq[i]));
`endif
      end

      // Wrap and empty: grant 6 puts ptr at 7, then channel 0 wins, then idle
      step(0, 1, 0, 8'h40, rnd_data(), 1);
      step(0, 1, 0, 8'h01, rnd_data(), 1);
`ifdef MUX_RR_N_1_RR_EN
      check_eq("wrap_ch", 64'(out_ch), 64'd0);
      check_eq("wrap_ptr", 64'(m_ptr), 64'(dut.ptr_q));
`endif
      held = out;
      step(0, 1, 0, 8'h00, rnd_data(), 1);
      check_eq("empty_valid", 64'(out_valid), 64'd0);
      check_eq("empty_hold", 64'(out), 64'(held));

      // Reset mid-stream with a held beat
      step(0, 1, 0, 8'hFF, rnd_data(), 0);
      step(1, 1, 0, 8'hFF, rnd_data(), 0);
      check_eq("midrst_valid", 64'(out_valid), 64'd0);
      check_eq("midrst_out", 64'(out), 64'd0);
      check_eq("midrst_ch", 64'(out_ch), 64'd0);
      step(0, 1, 0, 8'hFF, rnd_data(), 1);
      check_eq("resume_ch", 64'(out_ch), 64'd0);

`ifndef MUX_RR_N_1_RR_EN
      // mode ignored: always channel 5
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 5, 8'hFF, rnd_data(), 1);
         check_eq("noRR_ch", 64'(out_ch), 64'd5);
      end
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic r;
         logic [N-1:0] v;
         r = ($urandom_range(0, 49) == 0);
         v = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N - 1)) : N'($urandom);
         step(r, 1'($urandom), SW'($urandom), v, rnd_data(), ($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", err_count, chk_count);
      $finish;
   end
endmodule
